// File: rtl/pp_resp_arbiter.sv
// pp_resp_arbiter: round-robin arbiter that lets the UART, I2C and GPIO
// response groups share one upstream response FIFO. A granted group owns the
// FIFO until its last frame is accepted, so multi-frame responses never mix.
// Optional stall watchdog: define PP_ARB_TIMEOUT_EN to enable it.
module pp_resp_arbiter #(
    parameter int RAH_PACKET_WIDTH = 48,
    parameter int NUM_REQ          = 3,
    parameter int TIMEOUT_CYCLES   = 256
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0]                  req_last,
    input  logic [NUM_REQ*RAH_PACKET_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic                                f_full,
    input  logic                                f_a_full,
    output logic                                fifo_write_en,
    output logic [RAH_PACKET_WIDTH-1:0]         fifo_write_data,
    output logic [NUM_REQ-1:0]                  grant,
    output logic                                busy,
    output logic                                timeout_err
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // The watchdog counter is 16 bits wide, so the stall limit must fit it.
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("pp_resp_arbiter: TIMEOUT_CYCLES out of range 2..65535");
    end

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t                      state;
    logic [IW-1:0]               ptr;
    logic [IW-1:0]               gidx;
    logic [NUM_REQ-1:0]          grant_q;
    logic                        wr_en_q;
    logic [RAH_PACKET_WIDTH-1:0] wr_data_q;

    logic                        found;
    logic [IW-1:0]               pick_idx;
    logic [IW-1:0]               cand;
    logic                        ready_ok;
    logic                        gnt_valid;
    logic                        gnt_last;
    logic [RAH_PACKET_WIDTH-1:0] gnt_data;
    logic                        xfer;
    logic [IW-1:0]               next_ptr;

    // Search upward from the pointer (wrapping) for the first valid requester.
    always_comb begin
        found    = 1'b0;
        pick_idx = '0;
        cand     = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[cand]) begin
                found    = 1'b1;
                pick_idx = cand;
            end
            cand = (cand == IW'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
        end
    end

    // Handshake of the granted requester; the almost-full margin covers the in-flight write.
    always_comb begin
        ready_ok  = !f_a_full && !f_full;
        gnt_valid = req_valid[gidx];
        gnt_last  = req_last[gidx];
        gnt_data  = req_data[gidx*RAH_PACKET_WIDTH +: RAH_PACKET_WIDTH];
        req_ready = (state == XFER && ready_ok) ? grant_q : '0;
        xfer      = (state == XFER) && ready_ok && gnt_valid;
        next_ptr  = (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
    end

`ifdef PP_ARB_TIMEOUT_EN
    localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] stall_cnt;
    logic        timeout_q;

    // Arbitration FSM with registered write path and stall watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            gidx      <= '0;
            grant_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            stall_cnt <= '0;
            timeout_q <= 1'b0;
        end else begin
            wr_en_q   <= xfer;
            timeout_q <= 1'b0;
            if (xfer) begin
                wr_data_q <= gnt_data;
            end
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_q   <= NUM_REQ'(1) << pick_idx;
                        gidx      <= pick_idx;
                        stall_cnt <= '0;
                        state     <= XFER;
                    end
                end
                XFER: begin
                    if (xfer && gnt_last) begin
                        grant_q <= '0;
                        ptr     <= next_ptr;
                        state   <= IDLE;
                    end else if (xfer) begin
                        stall_cnt <= '0;
                    end else if (!gnt_valid && !f_a_full) begin
                        if (stall_cnt == STALL_LAST) begin
                            timeout_q <= 1'b1;
                            grant_q   <= '0;
                            ptr       <= next_ptr;
                            state     <= IDLE;
                        end else begin
                            stall_cnt <= stall_cnt + 16'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign timeout_err = timeout_q;
`else
    // Arbitration FSM with registered write path; grant is held until req_last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            gidx      <= '0;
            grant_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= xfer;
            if (xfer) begin
                wr_data_q <= gnt_data;
            end
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_q <= NUM_REQ'(1) << pick_idx;
                        gidx    <= pick_idx;
                        state   <= XFER;
                    end
                end
                XFER: begin
                    if (xfer && gnt_last) begin
                        grant_q <= '0;
                        ptr     <= next_ptr;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign timeout_err = 1'b0;
`endif

    assign grant           = grant_q;
    assign busy            = (state == XFER);
    assign fifo_write_en   = wr_en_q;
    assign fifo_write_data = wr_data_q;

endmodule

// File: tb/tb_pp_resp_arbiter.sv
// tb_pp_resp_arbiter: directed self-checking bench for pp_resp_arbiter
// (default build, watchdog disabled).
module tb_pp_resp_arbiter;

    localparam int W = 48;
    localparam int N = 3;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_last;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           f_full;
    logic           f_a_full;
    logic           fifo_write_en;
    logic [W-1:0]   fifo_write_data;
    logic [N-1:0]   grant;
    logic           busy;
    logic           timeout_err;

    int checks = 0;
    int errors = 0;

    pp_resp_arbiter #(
        .RAH_PACKET_WIDTH(W),
        .NUM_REQ(N),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_last(req_last),
        .req_data(req_data),
        .req_ready(req_ready),
        .f_full(f_full),
        .f_a_full(f_a_full),
        .fifo_write_en(fifo_write_en),
        .fifo_write_data(fifo_write_data),
        .grant(grant),
        .busy(busy),
        .timeout_err(timeout_err)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and land 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int idx, input logic [W-1:0] d);
        req_data[idx*W +: W] = d;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '0; req_last = '0; req_data = '0;
        f_full = 1'b0; f_a_full = 1'b0;
        #3;
        checks++; if (grant !== 3'b000) begin errors++; $display("[TB] FAIL reset_grant: got %b expected 000", grant); end
        checks++; if (fifo_write_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_en: got %b expected 0", fifo_write_en); end
        checks++; if (fifo_write_data !== 48'h0) begin errors++; $display("[TB] FAIL reset_wr_data: got %h expected 0", fifo_write_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout: got %b expected 0", timeout_err); end
        checks++; if (req_ready !== 3'b000) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 000", req_ready); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_round_robin();
        pulse_reset();
        set_data(0, 48'hA000_0000_000A);
        set_data(1, 48'hB000_0000_000B);
        set_data(2, 48'hC000_0000_000C);
        req_last = 3'b111; req_valid = 3'b111;
        step();
        checks++; if (grant !== 3'b001) begin errors++; $display("[TB] FAIL rr_grant0: got %b expected 001", grant); end
        checks++; if (req_ready !== 3'b001) begin errors++; $display("[TB] FAIL rr_ready0: got %b expected 001", req_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rr_busy0: got %b expected 1", busy); end
        step();
        checks++; if (fifo_write_en !== 1'b1 || fifo_write_data !== 48'hA000_0000_000A) begin errors++; $display("[TB] FAIL rr_writeA: got en=%b data=%h expected en=1 data=a0000000000a", fifo_write_en, fifo_write_data); end
        checks++; if (grant !== 3'b000 || busy !== 1'b0) begin errors++; $display("[TB] FAIL rr_idle0: got grant=%b busy=%b expected 000/0", grant, busy); end
        req_valid = 3'b110;
        step();
        checks++; if (grant !== 3'b010) begin errors++; $display("[TB] FAIL rr_grant1: got %b expected 010", grant); end
        step();
        checks++; if (fifo_write_en !== 1'b1 || fifo_write_data !== 48'hB000_0000_000B) begin errors++; $display("[TB] FAIL rr_writeB: got en=%b data=%h expected en=1 data=b0000000000b", fifo_write_en, fifo_write_data); end
        req_valid = 3'b100;
        step();
        checks++; if (grant !== 3'b100) begin errors++; $display("[TB] FAIL rr_grant2: got %b expected 100", grant); end
        step();
        checks++; if (fifo_write_en !== 1'b1 || fifo_write_data !== 48'hC000_0000_000C) begin errors++; $display("[TB] FAIL rr_writeC: got en=%b data=%h expected en=1 data=c0000000000c", fifo_write_en, fifo_write_data); end
        req_valid = 3'b011;
        step();
        checks++; if (grant !== 3'b001) begin errors++; $display("[TB] FAIL rr_wrap: got %b expected 001", grant); end
        step();
        req_valid = 3'b000;
        step();
        checks++; if (fifo_write_en !== 1'b0 || grant !== 3'b000) begin errors++; $display("[TB] FAIL rr_quiet: got en=%b grant=%b expected 0/000", fifo_write_en, grant); end
    endtask

    task automatic test_latency();
        pulse_reset();
        set_data(1, 48'h1234_5678_9ABC);
        req_last = 3'b010; req_valid = 3'b010;
        step();
        checks++; if (grant !== 3'b010) begin errors++; $display("[TB] FAIL lat_grant: got %b expected 010", grant); end
        checks++; if (req_ready !== 3'b010) begin errors++; $display("[TB] FAIL lat_ready: got %b expected 010", req_ready); end
        checks++; if (fifo_write_en !== 1'b0) begin errors++; $display("[TB] FAIL lat_early_write: got %b expected 0", fifo_write_en); end
        step();
        checks++; if (fifo_write_en !== 1'b1 || fifo_write_data !== 48'h1234_5678_9ABC) begin errors++; $display("[TB] FAIL lat_write: got en=%b data=%h expected en=1 data=123456789abc", fifo_write_en, fifo_write_data); end
        req_valid = 3'b000;
        step();
        checks++; if (fifo_write_en !== 1'b0 || fifo_write_data !== 48'h1234_5678_9ABC) begin errors++; $display("[TB] FAIL lat_hold: got en=%b data=%h expected en=0 data=123456789abc", fifo_write_en, fifo_write_data); end
    endtask

    task automatic test_no_interleave();
        pulse_reset();
        set_data(0, 48'hF1F1_0000_0001);
        set_data(2, 48'h6666_0000_0006);
        req_last = 3'b100; req_valid = 3'b101;
        step();
        checks++; if (grant !== 3'b001) begin errors++; $display("[TB] FAIL ni_grant_uart: got %b expected 001", grant); end
        checks++; if (req_ready !== 3'b001) begin errors++; $display("[TB] FAIL ni_ready_uart: got %b expected 001", req_ready); end
        step();
        checks++; if (fifo_write_en !== 1'b1 || fifo_write_data !== 48'hF1F1_0000_0001 || grant !== 3'b001) begin errors++; $display("[TB] FAIL ni_frame1: got en=%b data=%h grant=%b expected 1/f1f100000001/001", fifo_write_en, fifo_write_data, grant); end
        set_data(0, 48'hF2F2_0000_0002);
        step();
        checks++; if (fifo_write_en !== 1'b1 || fifo_write_data !== 48'hF2F2_0000_0002 || grant !== 3'b001) begin errors++; $display("[TB] FAIL ni_frame2: got en=%b data=%h grant=%b expected 1/f2f200000002/001", fifo_write_en, fifo_write_data, grant); end
        set_data(0, 48'hF3F3_0000_0003);
        req_last = 3'b101;
        step();
        checks++; if (fifo_write_en !== 1'b1 || fifo_write_data !== 48'hF3F3_0000_0003 || grant !== 3'b000) begin errors++; $display("[TB] FAIL ni_frame3: got en=%b data=%h grant=%b expected 1/f3f300000003/000", fifo_write_en, fifo_write_data, grant); end
        req_valid = 3'b100;
        step();
        checks++; if (grant !== 3'b100 || fifo_write_en !== 1'b0) begin errors++; $display("[TB] FAIL ni_grant_gpio: got grant=%b en=%b expected 100/0", grant, fifo_write_en); end
        step();
        checks++; if (fifo_write_en !== 1'b1 || fifo_write_data !== 48'h6666_0000_0006) begin errors++; $display("[TB] FAIL ni_gpio_write: got en=%b data=%h expected 1/666600000006", fifo_write_en, fifo_write_data); end
        req_valid = 3'b000;
        step();
    endtask

    task automatic test_almost_full();
        int bad;
        pulse_reset();
        set_data(0, 48'h1111_0000_0001);
        req_last = 3'b000; req_valid = 3'b001;
        step();
        checks++; if (req_ready !== 3'b001) begin errors++; $display("[TB] FAIL af_ready_before: got %b expected 001", req_ready); end
        step();
        checks++; if (fifo_write_en !== 1'b1 || fifo_write_data !== 48'h1111_0000_0001) begin errors++; $display("[TB] FAIL af_frame1: got en=%b data=%h expected 1/111100000001", fifo_write_en, fifo_write_data); end
        set_data(0, 48'h2222_0000_0002);
        req_last = 3'b001;
        f_a_full = 1'b1;
        #1;
        checks++; if (req_ready !== 3'b000) begin errors++; $display("[TB] FAIL af_ready_blocked: got %b expected 000", req_ready); end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (fifo_write_en !== 1'b0 || req_ready !== 3'b000 || grant !== 3'b001) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL af_stall: got %0d bad cycles expected 0", bad); end
        f_a_full = 1'b0;
        #1;
        checks++; if (req_ready !== 3'b001) begin errors++; $display("[TB] FAIL af_ready_resume: got %b expected 001", req_ready); end
        step();
        checks++; if (fifo_write_en !== 1'b1 || fifo_write_data !== 48'h2222_0000_0002 || grant !== 3'b000) begin errors++; $display("[TB] FAIL af_frame2: got en=%b data=%h grant=%b expected 1/222200000002/000", fifo_write_en, fifo_write_data, grant); end
        req_valid = 3'b000;
        step();
        checks++; if (fifo_write_en !== 1'b0) begin errors++; $display("[TB] FAIL af_no_dup: got %b expected 0", fifo_write_en); end
        f_full = 1'b1;
        req_valid = 3'b001;
        step();
        step();
        checks++; if (req_ready !== 3'b000 || fifo_write_en !== 1'b0) begin errors++; $display("[TB] FAIL af_full_block: got ready=%b en=%b expected 000/0", req_ready, fifo_write_en); end
        f_full = 1'b0;
        step();
        checks++; if (fifo_write_en !== 1'b1 || grant !== 3'b000) begin errors++; $display("[TB] FAIL af_full_resume: got en=%b grant=%b expected 1/000", fifo_write_en, grant); end
        req_valid = 3'b000;
        step();
    endtask

    task automatic test_hold();
        int bad;
        pulse_reset();
        set_data(1, 48'h5555_0000_0005);
        req_last = 3'b000; req_valid = 3'b010;
        step();
        step();
        checks++; if (fifo_write_en !== 1'b1 || grant !== 3'b010) begin errors++; $display("[TB] FAIL hold_first: got en=%b grant=%b expected 1/010", fifo_write_en, grant); end
        req_valid = 3'b001;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (grant !== 3'b010 || timeout_err !== 1'b0 || fifo_write_en !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL hold_grant: got %0d bad cycles expected 0", bad); end
        set_data(1, 48'h7777_0000_0007);
        req_last = 3'b010; req_valid = 3'b011;
        step();
        checks++; if (fifo_write_en !== 1'b1 || fifo_write_data !== 48'h7777_0000_0007 || grant !== 3'b000) begin errors++; $display("[TB] FAIL hold_finish: got en=%b data=%h grant=%b expected 1/777700000007/000", fifo_write_en, fifo_write_data, grant); end
        req_valid = 3'b000;
        step();
    endtask

    task automatic test_reset_mid_packet();
        req_last = 3'b000; req_valid = 3'b001;
        set_data(0, 48'h9999_0000_0009);
        step();
        checks++; if (grant !== 3'b001) begin errors++; $display("[TB] FAIL rmp_grant: got %b expected 001", grant); end
        step();
        checks++; if (fifo_write_en !== 1'b1) begin errors++; $display("[TB] FAIL rmp_wr_before: got %b expected 1", fifo_write_en); end
        rst_n = 1'b0;
        #1;
        checks++; if (grant !== 3'b000 || fifo_write_en !== 1'b0 || busy !== 1'b0 || fifo_write_data !== 48'h0) begin errors++; $display("[TB] FAIL rmp_async: got grant=%b en=%b busy=%b data=%h expected 000/0/0/0", grant, fifo_write_en, busy, fifo_write_data); end
        req_valid = 3'b000;
        step();
        rst_n = 1'b1;
        req_last = 3'b111; req_valid = 3'b111;
        step();
        checks++; if (grant !== 3'b001) begin errors++; $display("[TB] FAIL rmp_pointer: got %b expected 001", grant); end
        step();
        req_valid = 3'b000;
        step();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_latency();
        test_no_interleave();
        test_almost_full();
        test_hold();
        test_reset_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pp_resp_arbiter.md
Name: pp_resp_arbiter

Overview:
- Round-robin arbiter that lets the peripheral groups (UART, I2C, GPIO) share the single upstream response FIFO.
- Each group presents 48-bit response frames on a valid/ready channel.
- A granted group keeps the FIFO until it sends its last frame, so multi-frame serial responses are never interleaved.
- The block is the write-side counterpart of the command decoder: the decoder reads packets in, this block writes responses out.

Parameters:
- RAH_PACKET_WIDTH, 48, width of one response frame and of the FIFO write data.
- NUM_REQ, 3, number of requesters. Index 0 = UART group, 1 = I2C group, 2 = GPIO group.
- TIMEOUT_CYCLES, 256, stall limit used only by the optional watchdog. Legal range 2..65535.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous reset, active-low.
- req_valid  in  NUM_REQ  per-requester frame valid.
- req_last  in  NUM_REQ  per-requester "this frame ends the response".
- req_data  in  NUM_REQ*RAH_PACKET_WIDTH  frames, concatenated; requester i occupies bits [i*48 +: 48].
- req_ready  out  NUM_REQ  per-requester frame accepted.
- f_full  in  1  response FIFO full.
- f_a_full  in  1  response FIFO almost full; asserts with at least 1 free entry remaining.
- fifo_write_en  out  1  FIFO write strobe.
- fifo_write_data  out  RAH_PACKET_WIDTH  FIFO write data.
- grant  out  NUM_REQ  one-hot current owner; all zero when idle.
- busy  out  1  high while in XFER.
- timeout_err  out  1  one-cycle pulse on watchdog abort; tied 0 without the macro.

Behaviour:
- Reset (rst_n low, asynchronous): every output is 0.
  - grant = 0, fifo_write_en = 0, fifo_write_data = 0, busy = 0, timeout_err = 0.
  - Round-robin pointer = 0, state = IDLE.
  - Reset asserted mid-packet: the packet is dropped with no further writes; the requester must restart it after reset.
- State machine: IDLE, XFER.
- IDLE:
  - If any req_valid is high, register a grant to the first valid requester found by searching upward from the pointer, modulo NUM_REQ.
  - Go to XFER on the next edge.
  - If no req_valid is high, stay in IDLE.
- XFER:
  - req_ready[i] = grant[i] & !f_a_full & !f_full. This is combinational from registered state and the FIFO flags.
  - A beat transfers in any cycle where req_valid[g] & req_ready[g] for the granted requester g.
  - On a transfer whose req_last is high:
    - clear grant,
    - set pointer = (g+1) mod NUM_REQ,
    - go to IDLE.
  - There is always one IDLE cycle between packets.
  - Otherwise stay in XFER, holding the grant indefinitely, including while req_valid is low mid-packet.
- Write path:
  - On a transfer in cycle n: fifo_write_en = 1 and fifo_write_data = the accepted frame, both in cycle n+1. The write path is registered, so latency is 1 cycle.
  - With no transfer, fifo_write_en = 0 and fifo_write_data holds its last value.
  - f_a_full is sampled the same cycle as ready, so the one-entry margin absorbs the in-flight write.
  - No write is ever issued when f_full was high in the transfer cycle.
- Timing: req_valid rising in IDLE at cycle n gives grant at n+1, first possible transfer at n+1, first write at n+2.
- Simultaneous requests, pointer=0, all valid: serviced 0, 1, 2, then 0 again.
- A requester that drops valid while its packet is still pending keeps its place: the pointer does not advance until its req_last transfers.
- Single-beat packet (req_last on the first beat): legal. Occupancy is 2 cycles (XFER, IDLE).
- Inputs of non-granted requesters are ignored; their req_ready stays 0.
- busy = (state == XFER).

Optional Feature:
- Macro: PP_ARB_TIMEOUT_EN.
- With the macro:
  - A 16-bit stall counter runs in XFER. It clears on every transfer and on entry to XFER.
  - It increments only when req_valid[g] is low and the FIFO is not almost full, i.e. the requester is stalling, not the FIFO.
  - When the counter reaches TIMEOUT_CYCLES-1:
    - pulse timeout_err for one cycle,
    - clear grant,
    - advance the pointer to (g+1) mod NUM_REQ,
    - go to IDLE.
  - Frames already written stay in the FIFO.
- Without the macro: no counter, the grant is held indefinitely, and timeout_err is constant 0.

Test Plan:
- Reset mid-packet: during XFER with grant=001 and fifo_write_en high, drive rst_n low asynchronously -> grant=000, fifo_write_en=0 immediately, pointer=0.
- All three requesters assert valid with single-beat packets 0xA..., 0xB..., 0xC... -> FIFO writes A, B, C in that order; 2 cycles per packet; grant sequence 001, 010, 100.
- UART sends a 3-frame packet while GPIO is valid throughout -> UART's 3 frames are written consecutively; GPIO is granted only after UART's req_last beat; no interleaving.
- f_a_full held high for 5 cycles mid-packet -> req_ready=0 and no writes during those 5 cycles; transfers resume the cycle after f_a_full falls with no frame lost or duplicated.
- Latency: req_valid[1] rises in IDLE at cycle 10 with data 0x123456789ABC -> grant=010 at 11, req_ready[1]=1 at 11, fifo_write_en=1 with data 0x123456789ABC at 12.
- Watchdog (PP_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): I2C sends 1 non-last frame then drops valid -> timeout_err pulses 8 cycles later, grant clears, and pending UART is granted next. Without the macro, the grant stays 010 for 1000 cycles.
